// File: rtl/trap_scheduler.sv
// Grass-trap sequencer: toggles the trap phase on frame ticks and repaints the
// trap rectangle through the shared VGA plot port on every phase change.
module trap_scheduler #(
    parameter int unsigned X0          = 75,
    parameter int unsigned X1          = 200,
    parameter int unsigned Y0          = 236,
    parameter int unsigned Y1          = 250,
    parameter int unsigned PERIOD      = 30,
    parameter logic [2:0]  TRAP_COLOUR = 3'b100,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       plot_ready,
    input  logic [8:0] robot_x,
    input  logic [8:0] robot_y,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       trap_active,
    output logic       busy,
    output logic       done,
    output logic       hit
);

    localparam int unsigned CW = 9;
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CW-1:0] XL = CW'(X0);
    localparam logic [CW-1:0] XH = CW'(X1);
    localparam logic [CW-1:0] YL = CW'(Y0);
    localparam logic [CW-1:0] YH = CW'(Y1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] phase_cnt;
    logic          pending;

    logic toggle_c;
    logic accept_c;
    logic in_rect_c;

    assign toggle_c  = frame_tick && (phase_cnt == PHASE_LAST);
    assign accept_c  = plot && plot_ready;
    assign in_rect_c = (robot_x >= XL) && (robot_x <= XH) &&
                       (robot_y >= YL) && (robot_y <= YH);

    // Phase timebase, independent of drawing progress
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_cnt   <= '0;
            trap_active <= 1'b0;
        end else if (frame_tick) begin
            if (toggle_c) begin
                phase_cnt   <= '0;
                trap_active <= ~trap_active;
            end else begin
                phase_cnt <= phase_cnt + PW'(1);
            end
        end
    end

    // Sweep sequencer; a toggle re-arms pending after IDLE consumes it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pending    <= 1'b1;
            x_out      <= XL;
            y_out      <= YL;
            colour_out <= BG_COLOUR;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state      <= DRAW;
                        pending    <= 1'b0;
                        x_out      <= XL;
                        y_out      <= YL;
                        colour_out <= trap_active ? TRAP_COLOUR : BG_COLOUR;
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                DRAW: begin
                    if (accept_c) begin
                        if (x_out < XH) begin
                            x_out <= x_out + CW'(1);
                        end else begin
                            x_out <= XL;
                            if (y_out < YH) begin
                                y_out <= y_out + CW'(1);
                            end else begin
                                state <= DONE;
                                plot  <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
            if (toggle_c) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit <= 1'b0;
        end else begin
            hit <= trap_active && in_rect_c;
        end
    end

endmodule

// File: tb/tb_trap_scheduler.sv
// Bench for trap_scheduler: a negedge monitor tracks the trap phase and the
// expected raster stream; scenarios drive ticks, back-pressure, hits and reset.
module tb_trap_scheduler;

    localparam int TX0 = 75, TX1 = 200, TY0 = 236, TY1 = 250;
    localparam int TPERIOD = 2;
    localparam int W = TX1 - TX0 + 1;
    localparam int NPIX = W * (TY1 - TY0 + 1);
    localparam int TRAP_C = 4, BG_C = 0;

    logic       clock, resetn, frame_tick, plot_ready;
    logic [8:0] robot_x, robot_y, x_out, y_out;
    logic [2:0] colour_out;
    logic       plot, trap_active, busy, done, hit;

    trap_scheduler #(.PERIOD(TPERIOD)) dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
        .plot_ready(plot_ready), .robot_x(robot_x), .robot_y(robot_y),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
        .trap_active(trap_active), .busy(busy), .done(done), .hit(hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_x", int'(x_out), TX0);
        chk("rst_y", int'(y_out), TY0);
        chk("rst_colour", int'(colour_out), BG_C);
        chk("rst_plot", int'(plot), 0);
        chk("rst_trap_active", int'(trap_active), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
    endtask

    // Reference model state
    int m_cnt = 0;
    bit m_active = 0, prev_active = 0, m_hit = 0;
    bit in_sweep = 0;
    int k = 0, sweep_col = 0, sweep_cycles = 0, stalls = 0, last_sweep_cycles = 0;
    int sweeps_done = 0, cyc = 0, last_done_cyc = 0, last_gap = 0;
    int col_q[$];

    function automatic bit in_rect(input int rx, input int ry);
        return rx >= TX0 && rx <= TX1 && ry >= TY0 && ry <= TY1;
    endfunction

    // Outputs are compared against state that reflects all previous edges,
    // then the model consumes the inputs the coming edge will see.
    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            chk_reset_values();
            m_cnt = 0; m_active = 0; prev_active = 0; m_hit = 0; in_sweep = 0; k = 0;
        end else begin
            chk("trap_active", int'(trap_active), int'(m_active));
            chk("hit", int'(hit), int'(m_hit));
            if (plot) begin
                if (!in_sweep) begin
                    in_sweep = 1; k = 0; sweep_cycles = 0; stalls = 0;
                    sweep_col = prev_active ? TRAP_C : BG_C;
                    last_gap = cyc - last_done_cyc;
                end
                if (k < NPIX) begin
                    chk("pix_x", int'(x_out), TX0 + k % W);
                    chk("pix_y", int'(y_out), TY0 + k / W);
                    chk("pix_colour", int'(colour_out), sweep_col);
                end else begin
                    chk("pix_overrun", k, NPIX - 1);
                end
                chk("busy_draw", int'(busy), 1);
                sweep_cycles++;
                if (plot_ready) k++; else stalls++;
            end else if (in_sweep) begin
                in_sweep = 0;
                chk("sweep_len", k, NPIX);
                chk("sweep_cycles", sweep_cycles, NPIX + stalls);
                chk("done_pulse", int'(done), 1);
                chk("busy_done", int'(busy), 0);
                col_q.push_back(sweep_col);
                sweeps_done++;
                last_sweep_cycles = sweep_cycles;
                last_done_cyc = cyc;
            end else begin
                chk("done_idle", int'(done), 0);
            end
            m_hit = m_active && in_rect(int'(robot_x), int'(robot_y));
            prev_active = m_active;
            if (frame_tick) begin
                if (m_cnt == TPERIOD - 1) begin
                    m_cnt = 0;
                    m_active = !m_active;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1 frame_tick = 1'b1;
        @(posedge clock); #1 frame_tick = 1'b0;
    endtask

    task automatic wait_sweeps(input int n, input int budget);
        int c = 0;
        while (sweeps_done < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("sweeps_reached", sweeps_done, n);
    endtask

    task automatic wait_pixels(input int n, input int budget);
        int c = 0;
        while (!(in_sweep && k >= n) && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("pixels_reached", int'(in_sweep && k >= n), 1);
    endtask

    task automatic release_check();
        resetn = 1'b1;
        @(negedge clock);
        chk("plot_before_draw", int'(plot), 0);
        @(negedge clock);
        chk("first_plot", int'(plot), 1);
        chk("first_x", int'(x_out), TX0);
        chk("first_y", int'(y_out), TY0);
        chk("first_colour", int'(colour_out), BG_C);
        chk("first_busy", int'(busy), 1);
    endtask

    typedef struct {
        logic [8:0] rx;
        logic [8:0] ry;
        bit         act;
        bit         exp_hit;
    } hit_vec_t;

    hit_vec_t tab[10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{9'd75,  9'd236, 1'b1, 1'b1};
        tab[1] = '{9'd200, 9'd250, 1'b1, 1'b1};
        tab[2] = '{9'd74,  9'd240, 1'b1, 1'b0};
        tab[3] = '{9'd201, 9'd250, 1'b1, 1'b0};
        tab[4] = '{9'd100, 9'd251, 1'b1, 1'b0};
        tab[5] = '{9'd75,  9'd236, 1'b0, 1'b0};
        tab[6] = '{9'd200, 9'd250, 1'b0, 1'b0};
        tab[7] = '{9'd74,  9'd240, 1'b0, 1'b0};
        tab[8] = '{9'd201, 9'd250, 1'b0, 1'b0};
        tab[9] = '{9'd100, 9'd251, 1'b0, 1'b0};

        resetn = 1'b0; frame_tick = 1'b0; plot_ready = 1'b1;
        robot_x = 9'd0; robot_y = 9'd0;
        repeat (3) @(posedge clock);
        #1 chk_reset_values();

        // Background sweep out of reset, then quiet
        release_check();
        wait_sweeps(1, 3000);
        chk("first_sweep_colour", col_q[0], BG_C);
        chk("first_sweep_cycles", last_sweep_cycles, NPIX);
        repeat (50) @(negedge clock);
        chk("quiet_plot", int'(plot), 0);
        chk("quiet_busy", int'(busy), 0);
        chk("quiet_sweeps", sweeps_done, 1);

        // Toggle on the 2nd tick, draw latency, trap-coloured sweep
        tick();
        chk("no_toggle_tick1", int'(trap_active), 0);
        tick();
        chk("toggle_tick2", int'(trap_active), 1);
        @(negedge clock);
        chk("idle_after_toggle", int'(plot), 0);
        @(negedge clock);
        chk("draw_after_toggle", int'(plot), 1);
        chk("draw_colour", int'(colour_out), TRAP_C);
        wait_sweeps(2, 3000);
        chk("sweep2_colour", col_q[1], TRAP_C);
        tick(); tick();
        wait_sweeps(3, 3000);
        chk("sweep3_colour", col_q[2], BG_C);

        // Random back-pressure and robot motion
        tick(); tick();
        for (int c = 0; c < 10000 && sweeps_done < 4; c++) begin
            @(posedge clock); #1;
            plot_ready = 1'($urandom % 2);
            robot_x = 9'($urandom_range(60, 215));
            robot_y = 9'($urandom_range(230, 256));
        end
        @(posedge clock); #1 plot_ready = 1'b1;
        chk("random_sweeps", sweeps_done, 4);
        chk("sweep4_colour", col_q[3], TRAP_C);

        // Toggle mid-sweep: old colour finishes, new sweep 2 cycles after done
        tick(); tick();
        wait_pixels(500, 3000);
        tick(); tick();
        wait_sweeps(6, 6000);
        chk("midsweep_old_colour", col_q[4], BG_C);
        chk("midsweep_new_colour", col_q[5], TRAP_C);
        chk("restart_gap", last_gap, 2);

        // Hit table
        for (int i = 0; i < 10; i++) begin
            if (tab[i].act != m_active) begin
                tick(); tick();
                repeat (3) @(negedge clock);
            end
            @(posedge clock); #1;
            robot_x = tab[i].rx;
            robot_y = tab[i].ry;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("hit_tab%0d", i), int'(hit), int'(tab[i].exp_hit));
        end
        wait_sweeps(7, 3000);

        // Reset mid-sweep abandons it; fresh background sweep follows
        tick(); tick();
        wait_pixels(1000, 3000);
        @(posedge clock); #1 resetn = 1'b0;
        #1 chk_reset_values();
        repeat (3) @(posedge clock);
        #1 release_check();
        wait_sweeps(8, 3000);
        chk("post_reset_colour", col_q[7], BG_C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
